aes_enc_iter: RTL

AES_ENC_ITER -- requirements
Module: aes_enc_iter

---
 rtl/aes_pkg.sv | 56 +++++
 rtl/aes_enc_iter_if.sv | 22 ++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_enc_iter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: constants, FSM state type and GF(2^8)/S-box helpers shared by the
// AES encryption datapath and key expansion.
package aes_pkg;

  localparam int unsigned NK      = 4;
  localparam int unsigned NR      = 10;
  localparam int unsigned STATE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reduction polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add over xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[x];
  endfunction

endpackage

// File: rtl/aes_enc_iter_if.sv
// aes_enc_iter_if: plaintext/ciphertext handshake bundle of the encryptor.
interface aes_enc_iter_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [aes_pkg::STATE_W-1:0] plaintext;
  logic                        out_valid;
  logic                        out_ready;
  logic [aes_pkg::STATE_W-1:0] ciphertext;
  logic                        busy;

  modport master (
    output in_valid, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte combinational AES S-box lookup.
module aes_sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);
  import aes_pkg::*;

  // Table lookup shared with key expansion through the package.
  always_comb sbox_out = sbox(sbox_in);

endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryptor, one full round per clock.
// Byte 0 of every 128-bit block sits in bits [127:120]; round key r is w[128*r +: 128].
module aes_enc_iter #(
  parameter int unsigned NK = aes_pkg::NK,
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [128*(NR+1)-1:0] w,
  aes_enc_iter_if.slave         bus
);
  import aes_pkg::*;

  // Unsupported key/round configurations never accept a block.
  localparam logic       CFG_OK     = (NK == 4) && (NR == 10);
  localparam logic [3:0] LAST_ROUND = 4'(NR);

  enc_state_e         state_q, state_d;
  logic [3:0]         round_q, round_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic               ready_en_q, ready_en_d;

  logic [STATE_W-1:0] rk [NR+1];
  logic [7:0]         sb [16];
  logic [STATE_W-1:0] sr_vec;
  logic [STATE_W-1:0] mc_vec;
  logic [STATE_W-1:0] round_key;
  logic [STATE_W-1:0] round_out;
  logic               in_ready;
  logic               out_valid;

  // One MixColumns column: circulant {02,03,01,01}, byte 0 in the top bits.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = w[128*r +: 128];
  end

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .sbox_in  (data_q[127-8*g -: 8]),
      .sbox_out (sb[g])
    );
  end

  // Round datapath: ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
  always_comb begin
    // Byte i is row i%4, column i/4; output (r,c) takes input (r,(c+r)%4).
    sr_vec    = {sb[0],  sb[5],  sb[10], sb[15],
                 sb[4],  sb[9],  sb[14], sb[3],
                 sb[8],  sb[13], sb[2],  sb[7],
                 sb[12], sb[1],  sb[6],  sb[11]};
    mc_vec    = {mix_col(sr_vec[127:96]), mix_col(sr_vec[95:64]),
                 mix_col(sr_vec[63:32]),  mix_col(sr_vec[31:0])};
    round_key = rk[round_q];
    round_out = ((round_q == LAST_ROUND) ? sr_vec : mc_vec) ^ round_key;
  end

  // Next-state logic for the IDLE/ROUND/DONE sequencer and the state register.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    data_d     = data_q;
    ready_en_d = 1'b1;
    in_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = ready_en_q & CFG_OK;
        if (bus.in_valid && in_ready) begin
          data_d  = bus.plaintext ^ rk[0];
          round_d = 4'd1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        data_d = round_out;
        if (round_q == LAST_ROUND) begin
          round_d = '0;
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
      end
    endcase
  end

  // State registers with asynchronous reset; in_ready is held low until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      data_q     <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      data_q     <= data_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign out_valid      = (state_q == ST_DONE);
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.ciphertext = out_valid ? data_q : '0;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
